// File: rtl/axis_srl_fifo_pkg.sv
// Shared definitions for the SRL-based AXI4-Stream FIFO.
package axis_srl_fifo_pkg;

  localparam int unsigned C_SRL_ADDR_WIDTH_DEFAULT = 5;

  // Handshake events seen by the controller in one cycle.
  typedef struct packed {
    logic push;
    logic pop;
    logic load;
  } axis_hs_evt_t;

  // Words held in total: SRL depth plus the output register.
  function automatic int unsigned srl_capacity(input int unsigned addr_width);
    return (32'd1 << addr_width) + 32'd1;
  endfunction

endpackage

// File: rtl/axis_srl_fifo_bitcell.sv
// One-bit addressable shift register (SRL cell). Contents have no reset.
module axis_srl_fifo_bitcell
  import axis_srl_fifo_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH = C_SRL_ADDR_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    ce,
  input  logic                    d,
  input  logic [C_ADDR_WIDTH-1:0] a,
  output logic                    q
);

  localparam int unsigned DEPTH = 2 ** C_ADDR_WIDTH;

  logic [DEPTH-1:0] r_sr;

  // Shift new bit into address 0 on enable.
  always_ff @(posedge clk) begin
    if (ce) begin
      r_sr <= {r_sr[DEPTH-2:0], d};
    end
  end

  assign q = r_sr[a];

endmodule

// File: rtl/axis_srl_fifo_ctrl.sv
// AXI4-Stream FIFO controller over SRL storage with a registered output stage.
// Optional macro AXIS_SRL_FIFO_OCCUPANCY_EN adds the occupancy output port.
module axis_srl_fifo_ctrl
  import axis_srl_fifo_pkg::*;
#(
  parameter int unsigned C_WIDTH      = 8,
  parameter int unsigned C_ADDR_WIDTH = C_SRL_ADDR_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [C_WIDTH-1:0]        s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [C_WIDTH-1:0]        m_data
`ifdef AXIS_SRL_FIFO_OCCUPANCY_EN
  ,
  output logic [C_ADDR_WIDTH+1:0]   occupancy
`endif
);

  localparam int unsigned DEPTH = 2 ** C_ADDR_WIDTH;
  localparam int unsigned CW    = C_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [CW-1:0]           r_count;
  logic                    r_s_ready;
  logic                    r_m_valid;
  logic [C_WIDTH-1:0]      r_m_data;

  axis_hs_evt_t            w_evt;
  logic [CW-1:0]           w_count_next;
  logic [C_ADDR_WIDTH-1:0] w_rd_addr;
  logic [C_WIDTH-1:0]      w_srl_q;

  // Decode handshake events and next occupancy of the SRL.
  always_comb begin
    w_evt      = '0;
    w_evt.push = s_valid & r_s_ready;
    w_evt.pop  = r_m_valid & m_ready;
    w_evt.load = (r_count != '0) & (~r_m_valid | m_ready);
    w_count_next = r_count + CW'(w_evt.push) - CW'(w_evt.load);
  end

  // Oldest word sits at count-1; at count == DEPTH the low bits wrap to DEPTH-1.
  assign w_rd_addr = r_count[C_ADDR_WIDTH-1:0] - C_ADDR_WIDTH'(1);

  for (genvar gi = 0; gi < int'(C_WIDTH); gi++) begin : g_bit
    axis_srl_fifo_bitcell #(
      .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_bitcell (
      .clk (clk),
      .ce  (w_evt.push),
      .d   (s_data[gi]),
      .a   (w_rd_addr),
      .q   (w_srl_q[gi])
    );
  end

  // Count, registered ready and output stage; read uses pre-shift SRL contents.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_count   <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_count   <= w_count_next;
      r_s_ready <= (w_count_next != DEPTH_CNT);
      if (w_evt.load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_srl_q;
      end else if (w_evt.pop) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;

`ifdef AXIS_SRL_FIFO_OCCUPANCY_EN
  assign occupancy = (C_ADDR_WIDTH + 2)'(r_count) + (C_ADDR_WIDTH + 2)'(r_m_valid);
`endif

endmodule

// File: tb/tb_axis_srl_fifo_ctrl.sv
// Self-checking bench for axis_srl_fifo_ctrl against a queue-based FIFO model.
module tb_axis_srl_fifo_ctrl;
  import axis_srl_fifo_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned SRL_DEPTH = 32;

  logic         clk;
  logic         aresetn;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
`ifdef AXIS_SRL_FIFO_OCCUPANCY_EN
  logic [AW+1:0] occupancy;
`endif

  axis_srl_fifo_ctrl #(
    .C_WIDTH      (W),
    .C_ADDR_WIDTH (AW)
  ) u_dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef AXIS_SRL_FIFO_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: words waiting behind the output register, plus that register.
  logic [W-1:0] mdl_q[$];
  bit           mdl_mv;
  logic [W-1:0] mdl_md;
  bit           mdl_srdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_q.delete();
    mdl_mv   = 1'b0;
    mdl_md   = '0;
    mdl_srdy = 1'b0;
  endtask

  // One clock edge of FIFO behaviour.
  task automatic mdl_step(input logic sv, input logic [W-1:0] sd, input logic mr);
    bit push, pop, load;
    if (!aresetn) begin
      mdl_reset();
    end else begin
      push = sv && mdl_srdy;
      pop  = mdl_mv && mr;
      load = (mdl_q.size() != 0) && (!mdl_mv || mr);
      if (load) begin
        mdl_md = mdl_q.pop_front();
        mdl_mv = 1'b1;
      end else if (pop) begin
        mdl_mv = 1'b0;
      end
      if (push) mdl_q.push_back(sd);
      mdl_srdy = (mdl_q.size() != SRL_DEPTH);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_srdy"}, 32'(s_ready), 32'(mdl_srdy));
    chk({tag, "_mvld"}, 32'(m_valid), 32'(mdl_mv));
    chk({tag, "_mdat"}, 32'(m_data), 32'(mdl_md));
`ifdef AXIS_SRL_FIFO_OCCUPANCY_EN
    chk({tag, "_occ"}, 32'(occupancy), 32'(mdl_q.size()) + 32'(mdl_mv));
`endif
  endtask

  // Drive inputs for the next edge, advance, then compare 1 time unit later.
  task automatic cyc(input logic sv, input logic [W-1:0] sd, input logic mr, input string tag);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(posedge clk);
    mdl_step(sv, sd, mr);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int acc;
    int exp_word;

    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    aresetn = 1'b1;
    mdl_reset();
    #2;
    aresetn = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, "rst");
    chk("rst_srdy0", 32'(s_ready), 32'd0);
    chk("rst_mvld0", 32'(m_valid), 32'd0);
    chk("rst_mdat0", 32'(m_data), 32'h00);
    aresetn = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, "rel");
    chk("rel_srdy1", 32'(s_ready), 32'd1);

    // Single word: two-cycle latency, then drains.
    cyc(1'b1, 8'hA5, 1'b1, "one_push");
    chk("one_lat0", 32'(m_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, "one_out");
    chk("one_vld", 32'(m_valid), 32'd1);
    chk("one_dat", 32'(m_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, "one_gone");
    chk("one_empty", 32'(m_valid), 32'd0);

    // Fill with no consumer: capacity is SRL depth plus the output register.
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (s_ready) acc++;
      cyc(1'b1, W'(i), 1'b0, "fill");
    end
    chk("fill_cnt", 32'(acc), srl_capacity(AW));
    chk("fill_full", 32'(s_ready), 32'd0);

    // Drain everything in order.
    exp_word = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) begin
        chk("drain_dat", 32'(m_data), 32'(exp_word));
        exp_word++;
      end
      cyc(1'b0, 8'h00, 1'b1, "drain");
    end
    chk("drain_cnt", 32'(exp_word), 32'd33);
    chk("drain_empty", 32'(m_valid), 32'd0);

    // Streaming at one word per cycle after the two-cycle fill.
    for (int i = 0; i < 102; i++) begin
      cyc(i < 100, W'(i), 1'b1, "strm");
      if (i >= 1 && i <= 100) begin
        chk("strm_vld", 32'(m_valid), 32'd1);
        chk("strm_dat", 32'(m_data), 32'(i - 1));
      end
    end
    chk("strm_end", 32'(m_valid), 32'd0);

    // Asynchronous reset mid-operation discards buffered words.
    for (int i = 0; i < 10; i++) cyc(1'b1, W'(8'h40 + i), 1'b0, "preload");
    chk("preload_vld", 32'(m_valid), 32'd1);
    s_valid = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    mdl_reset();
    chk("arst_vld", 32'(m_valid), 32'd0);
    chk("arst_rdy", 32'(s_ready), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, "arst_hold");
    cyc(1'b0, 8'h00, 1'b1, "arst_hold");
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, "arst_idle");
    chk("arst_nostale", 32'(m_valid), 32'd0);
    cyc(1'b1, 8'h5C, 1'b1, "arst_push");
    cyc(1'b0, 8'h00, 1'b1, "arst_out");
    chk("arst_new_vld", 32'(m_valid), 32'd1);
    chk("arst_new_dat", 32'(m_data), 32'h5C);

    // Random stress against the model.
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(1, 0)), W'($urandom), 1'($urandom_range(1, 0)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
